// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_tx_fifo_if : write-side and UART_TX-side signals of the FIFO   |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
interface uart_tx_fifo_if #(
  parameter int p_DEPTH = 16,
  parameter int p_WIDTH = 8
);
  localparam int c_CW = $clog2(p_DEPTH) + 1;

  logic               i_Wr_DV;
  logic [p_WIDTH-1:0] i_Wr_Byte;
  logic               i_Clr_Ovf;
  logic               o_Full;
  logic               o_Empty;
  logic [c_CW-1:0]    o_Count;
  logic               o_Overflow;
  logic               o_Busy;
  logic [p_WIDTH-1:0] o_Tx_Byte;
  logic               o_Tx_Ready;
  logic               i_Tx_Completed;

  modport slave (
    input  i_Wr_DV, i_Wr_Byte, i_Clr_Ovf, i_Tx_Completed,
    output o_Full, o_Empty, o_Count, o_Overflow, o_Busy, o_Tx_Byte, o_Tx_Ready
  );

  modport master (
    output i_Wr_DV, i_Wr_Byte, i_Clr_Ovf, i_Tx_Completed,
    input  o_Full, o_Empty, o_Count, o_Overflow, o_Busy, o_Tx_Byte, o_Tx_Ready
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_tx_fifo : circular byte FIFO that paces bytes into UART_TX     |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module uart_tx_fifo #(
  parameter int p_DEPTH      = 16,
  parameter int p_WIDTH      = 8,
  parameter int p_READY_CLKS = 2
) (
  input  logic           i_Clk,
  input  logic           i_Rst_n,
  uart_tx_fifo_if.slave  bus
);
  localparam int c_AW = $clog2(p_DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam int c_HW = $clog2(p_READY_CLKS + 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  logic [p_WIDTH-1:0] mem_q [p_DEPTH];
  logic [c_AW-1:0]    rd_ptr_q;
  logic [c_AW-1:0]    wr_ptr_q;
  logic [c_CW-1:0]    count_q;
  logic [c_HW-1:0]    hold_q, hold_d;
  logic               done_q;
  state_t             state_q, state_d;
  logic [p_WIDTH-1:0] tx_byte_q, tx_byte_d;
  logic               tx_ready_q, tx_ready_d;
  logic               ovf_q;

  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_full;
  logic w_done_rise;

  assign w_full      = (count_q == c_CW'(p_DEPTH));
  assign w_done_rise = bus.i_Tx_Completed & ~done_q;
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign w_push      = bus.i_Wr_DV & (~w_full | w_pop);
  assign w_drop      = bus.i_Wr_DV & ~w_push;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    tx_byte_d  = tx_byte_q;
    tx_ready_d = tx_ready_q;
    w_pop      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          w_pop      = 1'b1;
          tx_byte_d  = mem_q[rd_ptr_q];
          tx_ready_d = 1'b1;
          hold_d     = c_HW'(1);
          state_d    = ST_START;
        end
      end
      ST_START: begin
        // Completion edges arriving here are ignored on purpose.
        if (hold_q == c_HW'(p_READY_CLKS)) begin
          tx_ready_d = 1'b0;
          state_d    = ST_WAIT_DONE;
        end else begin
          hold_d = hold_q + c_HW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (w_done_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      tx_byte_q  <= '0;
      tx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      tx_byte_q  <= tx_byte_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= bus.i_Tx_Completed;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + c_AW'(1);
      if (w_push) wr_ptr_q <= wr_ptr_q + c_AW'(1);
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + c_CW'(1);
        2'b01:   count_q <= count_q - c_CW'(1);
        default: count_q <= count_q;
      endcase
      if (w_drop)             ovf_q <= 1'b1;
      else if (bus.i_Clr_Ovf) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (w_push) mem_q[wr_ptr_q] <= bus.i_Wr_Byte;
  end

  assign bus.o_Full     = w_full;
  assign bus.o_Empty    = (count_q == '0);
  assign bus.o_Count    = count_q;
  assign bus.o_Overflow = ovf_q;
  assign bus.o_Busy     = (state_q != ST_IDLE);
  assign bus.o_Tx_Byte  = tx_byte_q;
  assign bus.o_Tx_Ready = tx_ready_q;
endmodule
`default_nettype wire
